// File: rtl/load_store_unit.sv
// Load/store unit between execute and writeback. It issues one data-memory access
// at a time, aligns store data and loads, and aborts accesses that outlive TIMEOUT_CYCLES.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] store_data_i,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] alu_result_o,
   output logic [31:0] data_o,
   output logic [4:0]  sel_rd_o,
   output logic        misaligned_o,
   output logic        err_o
);
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam int unsigned TMO = TIMEOUT_CYCLES;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state;
   logic [31:0] instr_q, alu_q;
   logic [7:0]  cnt;

   logic [6:0]  opc;
   logic [1:0]  size;
   logic        is_st, is_mem, mis;
   logic [3:0]  be;
   logic [31:0] wdata, shifted, ld_data;
   logic [4:0]  rd;
   logic [7:0]  cnt_nxt;
   logic        timeout;

   assign opc    = instr_i[6:0];
   assign size   = instr_i[13:12];
   assign is_st  = (opc == OP_STORE);
   assign is_mem = (opc == OP_LOAD) || is_st;
   assign mis    = is_mem && ((size == 2'b01 && alu_result_i[0]) ||
                              (size == 2'b10 && alu_result_i[1:0] != 2'b00));
   assign rd     = (is_st || opc == OP_BRANCH || mis) ? 5'd0 : instr_i[11:7];

   always_comb begin
      be    = 4'b1111;
      wdata = store_data_i;
      case (size)
         2'b00: begin
            be    = 4'b0001 << alu_result_i[1:0];
            wdata = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane extraction uses the captured instruction, since the inputs may move on.
   assign shifted = mem_rdata_i >> {alu_q[1:0], 3'b000};
   always_comb begin
      ld_data = shifted;
      case (instr_q[14:12])
         3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ld_data = {24'd0, shifted[7:0]};
         3'b101:  ld_data = {16'd0, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

   assign cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   assign timeout = (32'(cnt_nxt) >= TMO);
   assign stall_o = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         instr_q      <= '0;
         alu_q        <= '0;
         cnt          <= '0;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_be_o     <= '0;
         mem_wdata_o  <= '0;
         valid_o      <= 1'b0;
         instr_o      <= '0;
         alu_result_o <= '0;
         data_o       <= '0;
         sel_rd_o     <= '0;
         misaligned_o <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         valid_o      <= 1'b0;
         misaligned_o <= 1'b0;
         err_o        <= 1'b0;
         case (state)
            IDLE: if (valid_i) begin
               instr_q <= instr_i;
               alu_q   <= alu_result_i;
               cnt     <= '0;
               if (is_mem && !mis) begin
                  state       <= REQ;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= is_st;
                  mem_addr_o  <= {alu_result_i[31:2], 2'b00};
                  mem_be_o    <= be;
                  mem_wdata_o <= wdata;
               end else begin
                  valid_o      <= 1'b1;
                  instr_o      <= instr_i;
                  alu_result_o <= alu_result_i;
                  data_o       <= '0;
                  sel_rd_o     <= rd;
                  misaligned_o <= mis;
               end
            end
            REQ: begin
               cnt <= cnt_nxt;
               // A grant in the same cycle as the timeout still completes normally.
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  if (instr_q[5]) begin
                     state        <= IDLE;
                     valid_o      <= 1'b1;
                     instr_o      <= instr_q;
                     alu_result_o <= alu_q;
                     data_o       <= '0;
                     sel_rd_o     <= '0;
                  end else begin
                     state <= WAIT;
                  end
               end else if (timeout) begin
                  state        <= IDLE;
                  mem_req_o    <= 1'b0;
                  mem_we_o     <= 1'b0;
                  valid_o      <= 1'b1;
                  err_o        <= 1'b1;
                  instr_o      <= instr_q;
                  alu_result_o <= alu_q;
                  data_o       <= '0;
                  sel_rd_o     <= '0;
               end
            end
            WAIT: begin
               cnt <= cnt_nxt;
               if (mem_rvalid_i || timeout) begin
                  state        <= IDLE;
                  valid_o      <= 1'b1;
                  err_o        <= !mem_rvalid_i;
                  instr_o      <= instr_q;
                  alu_result_o <= alu_q;
                  data_o       <= mem_rvalid_i ? ld_data : 32'd0;
                  sel_rd_o     <= mem_rvalid_i ? instr_q[11:7] : 5'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference model,
// per-cycle comparison, directed corner cases and randomized instruction streams.
module tb_load_store_unit;
   localparam int T = 16;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        valid_i = 1'b0, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] instr_i = '0, alu_result_i = '0, store_data_i = '0, mem_rdata_i = '0;
   logic        stall_o, mem_req_o, mem_we_o, valid_o, misaligned_o, err_o;
   logic [31:0] mem_addr_o, mem_wdata_o, instr_o, alu_result_o, data_o;
   logic [3:0]  mem_be_o;
   logic [4:0]  sel_rd_o;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .instr_i(instr_i),
      .alu_result_i(alu_result_i), .store_data_i(store_data_i), .stall_o(stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .valid_o(valid_o),
      .instr_o(instr_o), .alu_result_o(alu_result_o), .data_o(data_o),
      .sel_rd_o(sel_rd_o), .misaligned_o(misaligned_o), .err_o(err_o));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   bit chk_en = 0;

   // Expected outputs for the current cycle, written by the driver after each edge.
   logic        e_stall = 0, e_req = 0, e_we = 0, e_valid = 0, e_mis = 0, e_err = 0;
   logic [31:0] e_addr = 0, e_wdata = 0, e_instr = 0, e_alu = 0, e_data = 0;
   logic [3:0]  e_be = 0;
   logic [4:0]  e_sel = 0;

   typedef struct {
      bit          is_mem, is_store, mis;
      logic [3:0]  be;
      logic [31:0] wdata, data;
      logic [4:0]  sel;
   } ref_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ref_t ref_op(input logic [31:0] ins, input logic [31:0] alu,
                                   input logic [31:0] sd, input logic [31:0] rdata);
      ref_t r;
      int unsigned size, off;
      logic [31:0] v;
      logic [6:0] opc;
      opc        = ins[6:0];
      r.is_store = (opc == 7'b0100011);
      r.is_mem   = r.is_store || (opc == 7'b0000011);
      size       = 1 << ins[13:12];
      off        = alu % 4;
      r.mis      = r.is_mem && (alu % size != 0);
      r.be       = 4'(((1 << size) - 1) << off);
      r.wdata    = (size == 1) ? sd[7:0] * 32'h01010101 :
                   (size == 2) ? sd[15:0] * 32'h00010001 : sd;
      v          = rdata >> (8 * off);
      if (size == 1)      r.data = ins[14] ? (v & 32'hFF)   : 32'($signed(v[7:0]));
      else if (size == 2) r.data = ins[14] ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
      else                r.data = v;
      r.sel = (r.is_store || opc == 7'b1100011 || r.mis) ? 5'd0 : ins[11:7];
      return r;
   endfunction

   always @(negedge clk) if (chk_en) begin
      chk("stall", 32'(stall_o), 32'(e_stall));
      chk("mem_req", 32'(mem_req_o), 32'(e_req));
      chk("valid", 32'(valid_o), 32'(e_valid));
      chk("misaligned", 32'(misaligned_o), 32'(e_valid & e_mis));
      chk("err", 32'(err_o), 32'(e_valid & e_err));
      if (e_req) begin
         chk("mem_addr", mem_addr_o, e_addr);
         chk("mem_be", 32'(mem_be_o), 32'(e_be));
         chk("mem_we", 32'(mem_we_o), 32'(e_we));
         if (e_we) chk("mem_wdata", mem_wdata_o, e_wdata);
      end
      if (e_valid) begin
         chk("instr_o", instr_o, e_instr);
         chk("alu_result_o", alu_result_o, e_alu);
         chk("data_o", data_o, e_data);
         chk("sel_rd", 32'(sel_rd_o), 32'(e_sel));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [31:0] ins, alu, data, input logic [4:0] sel,
                        input logic mis, err);
      e_valid = 1; e_instr = ins; e_alu = alu; e_data = data; e_sel = sel;
      e_mis = mis; e_err = err; e_stall = 0; e_req = 0;
   endtask

   task automatic idle(input int n);
      valid_i = 0;
      for (int i = 0; i < n; i++) begin
         mem_rvalid_i = 1'($urandom);
         mem_rdata_i  = $urandom;
         step();
         e_valid = 0; e_mis = 0; e_err = 0;
      end
      mem_rvalid_i = 0;
   endtask

   // g: cycle index (after accept) carrying the grant; r: cycle index carrying rvalid.
   task automatic do_instr(input logic [31:0] ins, alu, sd, rdata, input int g, r);
      ref_t rf;
      bit in_req, done;
      int k;
      rf = ref_op(ins, alu, sd, rdata);
      valid_i = 1; instr_i = ins; alu_result_i = alu; store_data_i = sd;
      mem_gnt_i = 0; mem_rvalid_i = 0;
      step();
      e_valid = 0; e_mis = 0; e_err = 0;
      if (!rf.is_mem || rf.mis) begin
         pulse(ins, alu, 32'd0, rf.sel, rf.mis, 1'b0);
         valid_i = 0;
         return;
      end
      e_stall = 1; e_req = 1; e_we = rf.is_store; e_addr = {alu[31:2], 2'b00};
      e_be = rf.be; e_wdata = rf.wdata;
      in_req = 1; done = 0; k = 0;
      while (!done) begin
         mem_gnt_i    = in_req && (k == g);
         mem_rvalid_i = in_req ? (k < g && 1'($urandom)) : (k == r);
         mem_rdata_i  = (!in_req && k == r) ? rdata : $urandom;
         step();
         mem_gnt_i = 0; mem_rvalid_i = 0;
         if (in_req && k == g) begin
            if (rf.is_store) begin pulse(ins, alu, 32'd0, 5'd0, 0, 0); done = 1; end
            else begin in_req = 0; e_req = 0; end
         end else if (!in_req && k == r) begin
            pulse(ins, alu, rf.data, rf.sel, 0, 0); done = 1;
         end else if (k + 1 >= T) begin
            pulse(ins, alu, 32'd0, 5'd0, 0, 1); done = 1;
         end
         k++;
      end
      valid_i = 0;
   endtask

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [4:0] rd);
      logic [31:0] i;
      i = $urandom;
      i[6:0] = opc; i[11:7] = rd; i[14:12] = f3;
      return i;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ref_t rf;
      logic [6:0] nm_ops [4] = '{7'b0010011, 7'b0110011, 7'b1100011, 7'b0110111};
      logic [2:0] ld_f3  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      // Model pinned against hand-computed values.
      rf = ref_op(mk(7'b0100011, 3'b000, 5'd0), 32'h1003, 32'hAB, 0);
      chk("model_sb_be", 32'(rf.be), 32'h8);
      chk("model_sb_wdata", rf.wdata, 32'hABABABAB);
      rf = ref_op(mk(7'b0000011, 3'b000, 5'd7), 32'h2001, 0, 32'h000080FF);
      chk("model_lb", rf.data, 32'hFFFFFF80);
      rf = ref_op(mk(7'b0000011, 3'b100, 5'd7), 32'h2001, 0, 32'h000080FF);
      chk("model_lbu", rf.data, 32'h00000080);
      rf = ref_op(mk(7'b0000011, 3'b010, 5'd7), 32'h2002, 0, 0);
      chk("model_lw_mis", 32'(rf.mis), 32'd1);

      #3;
      chk("rst_stall", 32'(stall_o), 0);
      chk("rst_req", 32'(mem_req_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_data", data_o, 0);
      @(negedge clk); rst_n = 1;
      step();
      chk_en = 1;

      do_instr({12'h010, 5'd0, 3'b000, 5'd5, 7'b0010011}, 32'h10, 0, 0, 0, 0);
      chk("addi_valid", 32'(valid_o), 1);
      chk("addi_sel", 32'(sel_rd_o), 5);
      chk("addi_data", data_o, 0);
      do_instr(mk(7'b0100011, 3'b000, 5'd3), 32'h1003, 32'hAB, 0, 2, 0);
      chk("sb_sel", 32'(sel_rd_o), 0);
      do_instr(mk(7'b0000011, 3'b000, 5'd7), 32'h2001, 0, 32'h000080FF, 1, 3);
      chk("lb_data", data_o, 32'hFFFFFF80);
      chk("lb_sel", 32'(sel_rd_o), 7);
      do_instr(mk(7'b0000011, 3'b100, 5'd7), 32'h2001, 0, 32'h000080FF, 0, 1);
      chk("lbu_data", data_o, 32'h00000080);
      do_instr(mk(7'b0000011, 3'b010, 5'd7), 32'h2002, 0, 0, 0, 0);
      chk("lw_mis", 32'(misaligned_o), 1);
      chk("lw_mis_sel", 32'(sel_rd_o), 0);
      do_instr(mk(7'b0000011, 3'b001, 5'd9), 32'h3000, 0, 0, 1000, 1000);
      chk("lh_tmo_err", 32'(err_o), 1);
      idle(1);
      chk("lh_tmo_stall", 32'(stall_o), 0);
      chk("lh_tmo_req", 32'(mem_req_o), 0);
      // Grant on the last allowed cycle wins; the load then times out in WAIT.
      do_instr(mk(7'b0000011, 3'b010, 5'd4), 32'h40, 0, 0, T - 1, 1000);
      do_instr(mk(7'b0100011, 3'b001, 5'd4), 32'h42, 32'h1234, 0, T - 1, 0);
      idle(1);

      // Reset while waiting for read data.
      valid_i = 1; instr_i = mk(7'b0000011, 3'b010, 5'd6); alu_result_i = 32'h3000;
      step();
      e_valid = 0; e_stall = 1; e_req = 1; e_we = 0; e_addr = 32'h3000; e_be = 4'hF;
      mem_gnt_i = 1;
      step();
      mem_gnt_i = 0; valid_i = 0; e_req = 0;
      chk_en = 0;
      #2 rst_n = 0;
      #1;
      chk("arst_stall", 32'(stall_o), 0);
      chk("arst_req", 32'(mem_req_o), 0);
      chk("arst_valid", 32'(valid_o), 0);
      chk("arst_sel_data", {27'd0, sel_rd_o} | data_o | instr_o, 0);
      @(negedge clk); rst_n = 1;
      e_stall = 0; e_req = 0; e_valid = 0; e_mis = 0; e_err = 0;
      chk_en = 1;
      idle(3);
      chk("arst_no_wb", 32'(valid_o), 0);

      for (int n = 0; n < 300; n++) begin
         int kind, g, r;
         logic [31:0] ins, alu;
         kind = $urandom_range(0, 2);
         alu  = $urandom;
         if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
         g = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 5);
         r = ($urandom_range(0, 9) == 0) ? 100 : g + 1 + $urandom_range(0, 4);
         if (kind == 0)      ins = mk(nm_ops[$urandom_range(0, 3)], 3'($urandom), 5'($urandom));
         else if (kind == 1) ins = mk(7'b0000011, ld_f3[$urandom_range(0, 4)], 5'($urandom));
         else                ins = mk(7'b0100011, 3'($urandom_range(0, 2)), 5'($urandom));
         do_instr(ins, alu, $urandom, $urandom, g, r);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(2);
      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
